// File: rtl/keypad_scan.sv
// Purpose: scan a 4x4 active-low keypad, debounce presses, shift accepted key codes into a 32-bit entry register.
// Latency: o_key_vld one clk after the scan_done closing the DEBOUNCE-th matching scan, plus 2 clk column sync.
// Backpressure: none; each press gives one single-cycle pulse and the entry register always accepts it.
module keypad_scan #(
  parameter int DIV_BITS = 15,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  i_col,
  input  logic        i_clr,
  output logic [3:0]  o_row,
  output logic [3:0]  o_key_code,
  output logic        o_key_vld,
  output logic        o_key_held,
  output logic [31:0] o_data
);

  // Debounce counter only has to reach DEBOUNCE.
  localparam int DW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] ONE      = DW'(1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEB  = 2'd1,
    HELD = 2'd2,
    REL  = 2'd3
  } state_t;

  // Scan timing
  logic [DIV_BITS-1:0] cnt;
  logic                scan_tick;
  logic                scan_done;
  logic [1:0]          row_idx;
  logic [1:0]          row_next;

  // Column synchronizer and per-row decode
  logic [3:0] col_meta;
  logic [3:0] col_sync;
  logic [3:0] col_hit;
  logic       row_hit;
  logic [1:0] col_idx;

  // Per-scan candidate accumulated over rows 0..2, completed with row 3
  logic       acc_any;
  logic [3:0] acc_code;
  logic       cand_any;
  logic [3:0] cand;

  // Debounce FSM
  state_t     state;
  logic [DW-1:0] dcnt;
  logic [3:0] latched;
  logic       accept;
  logic [3:0] accept_code;

  assign scan_tick = &cnt;
  assign scan_done = scan_tick && (row_idx == 2'd3);
  assign row_next  = row_idx + 2'd1;

  // Free-running divider; its all-ones value marks a scan tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_BITS'(1);
    end
  end

  // Two-flop synchronizer for the asynchronous column lines (idle = pulled up).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= i_col;
      col_sync <= col_meta;
    end
  end

  // Advance to the next row on each tick; the row drive is registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_idx <= 2'd0;
      o_row   <= 4'b1110;
    end else if (scan_tick) begin
      row_idx <= row_next;
      o_row   <= ~(4'b0001 << row_next);
    end
  end

  assign col_hit = ~col_sync;
  assign row_hit = |col_hit;

  // Lowest pressed column in the row currently being sampled.
  always_comb begin
    col_idx = 2'd3;
    if (col_hit[2]) col_idx = 2'd2;
    if (col_hit[1]) col_idx = 2'd1;
    if (col_hit[0]) col_idx = 2'd0;
  end

  // Remember the first (lowest-index) key seen so far in this scan; row 0 starts afresh.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_any  <= 1'b0;
      acc_code <= 4'd0;
    end else if (scan_tick && ((row_idx == 2'd0) || !acc_any)) begin
      acc_any  <= row_hit;
      acc_code <= {row_idx, col_idx};
    end
  end

  // Scan result including the row sampled on scan_done itself.
  assign cand_any = acc_any || row_hit;
  assign cand     = acc_any ? acc_code : {row_idx, col_idx};

  // Decide whether this scan completes a press, and which code it reports.
  always_comb begin
    accept      = 1'b0;
    accept_code = latched;
    if (scan_done) begin
      if ((state == IDLE) && cand_any && (DEBOUNCE == 1)) begin
        accept      = 1'b1;
        accept_code = cand;
      end
      if ((state == DEB) && cand_any && (cand == latched) && (dcnt == DEB_LAST)) begin
        accept = 1'b1;
      end
    end
  end

  // Debounce FSM with registered key outputs and the entry shift register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      dcnt       <= '0;
      latched    <= 4'd0;
      o_key_code <= 4'd0;
      o_key_vld  <= 1'b0;
      o_key_held <= 1'b0;
      o_data     <= 32'd0;
    end else begin
      o_key_vld <= 1'b0;

      // Clear wins over a same-cycle accept; that key is not shifted in.
      if (i_clr) begin
        o_data <= 32'd0;
      end else if (accept) begin
        o_data <= {o_data[27:0], accept_code};
      end

      if (accept) begin
        o_key_code <= accept_code;
        o_key_vld  <= 1'b1;
        o_key_held <= 1'b1;
      end

      if (scan_done) begin
        case (state)
          IDLE: begin
            if (cand_any) begin
              latched <= cand;
              if (DEBOUNCE == 1) begin
                state <= HELD;
                dcnt  <= '0;
              end else begin
                state <= DEB;
                dcnt  <= ONE;
              end
            end
          end
          DEB: begin
            if (cand_any && (cand == latched)) begin
              if (dcnt == DEB_LAST) begin
                state <= HELD;
                dcnt  <= '0;
              end else begin
                dcnt <= dcnt + ONE;
              end
            end else begin
              // Key vanished or changed: start over.
              state <= IDLE;
              dcnt  <= '0;
            end
          end
          HELD: begin
            if (!cand_any) begin
              if (DEBOUNCE == 1) begin
                state      <= IDLE;
                dcnt       <= '0;
                o_key_held <= 1'b0;
              end else begin
                state <= REL;
                dcnt  <= ONE;
              end
            end
          end
          REL: begin
            if (cand_any) begin
              // Release glitch: back to held, no new event.
              state <= HELD;
              dcnt  <= '0;
            end else if (dcnt == DEB_LAST) begin
              state      <= IDLE;
              dcnt       <= '0;
              o_key_held <= 1'b0;
            end else begin
              dcnt <= dcnt + ONE;
            end
          end
          default: begin
            state <= IDLE;
            dcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule
